// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MA-stage data-memory path.
// Word-organised RAM behind a valid/ready request and a single-cycle
// response strobe, with programmable wait states, B/H/W access with
// sign/zero extension, and fault reporting for bad accesses.
// Optional MMIO display register enabled by defining DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] seg_out
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic MMIO_EN = 1'b1;
`else
  localparam logic MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        in_resp;

  // Access decode of the captured request
  logic        mmio_hit;
  logic        out_of_range;
  logic        size_bad;
  logic        misaligned;
  logic        acc_err;

  // Storage and datapath
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata_al;
  logic        mem_we;
  logic [31:0] mmio_rdata;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_data;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_resp   = (state_q == S_RESP);

  assign widx = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  // Next-state logic: capture request on accept, count wait states, respond once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, wait counter and captured request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Fault classification of the captured access
  always_comb begin
    mmio_hit     = MMIO_EN && (addr_q == MMIO_ADDR);
    out_of_range = !mmio_hit && ({1'b0, addr_q} >= LIMIT);
    size_bad     = (size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111);
    unique case (size_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    acc_err = out_of_range || size_bad || misaligned ||
              (we_q && size_q[2]) ||
              (mmio_hit && (size_q != 3'b010));
  end

  // Store lane enables; data is replicated so every enabled lane sees its bytes
  always_comb begin
    be       = 4'b1111;
    wdata_al = wdata_q;
    unique case (size_q[1:0])
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata_q[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_al = wdata_q;
      end
    endcase
  end

  // Stores commit on the edge that ends RESP; reset in that cycle drops them
  assign mem_we = in_resp && we_q && !acc_err && !mmio_hit && !rst;

  // Byte-enabled RAM write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= wdata_al[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] seg_q, seg_d;

  // Display register takes word stores to the MMIO address at the RESP edge
  always_comb begin
    seg_d = seg_q;
    if (in_resp && we_q && mmio_hit && !acc_err) begin
      seg_d = wdata_q;
    end
  end

  // Display register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out    = seg_q;
  assign mmio_rdata = seg_q;
`else
  assign seg_out    = '0;
  assign mmio_rdata = '0;
`endif

  // Load path: array is read in the RESP cycle, lane-selected and extended
  always_comb begin
    rword = mmio_hit ? mmio_rdata : mem_q[widx];
    rbyte = 8'(rword >> {lane, 3'b000});
    rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
    unique case (size_q)
      3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
      3'b010:  ld_data = rword;
      3'b100:  ld_data = {24'h0, rbyte};
      3'b101:  ld_data = {16'h0, rhalf};
      default: ld_data = '0;
    endcase
  end

  assign resp_valid = in_resp;
  assign resp_err   = in_resp && acc_err;
  assign resp_rdata = (in_resp && !we_q && !acc_err) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// traffic compared against a byte-addressed behavioural memory model.
// Build with DMEM_RESPONDER_MMIO_EN defined to exercise the MMIO register.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LAT   = 2;
  localparam int unsigned BYTES = DEPTH * 4;

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic MMIO = 1'b1;
`else
  localparam logic MMIO = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, seg_out;

  logic        z_valid, z_ready, z_we;
  logic [31:0] z_addr, z_wdata;
  logic [2:0]  z_size;
  logic        z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata, z_seg_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  mbytes [BYTES];
  logic [31:0] mseg;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t q[$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .seg_out(seg_out)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
    .req_addr(z_addr), .req_size(z_size), .req_wdata(z_wdata),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
    .seg_out(z_seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: architectural effect of one access on a byte-addressed memory
  task automatic mdl_access(input logic we, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned n;
    logic        sgn, legal, mm, inr;
    logic [31:0] v;
    legal = 1'b1; sgn = 1'b0; n = 1;
    case (sz)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; end
      3'd4: begin n = 1; end
      3'd5: begin n = 2; end
      default: legal = 1'b0;
    endcase
    mm  = MMIO && (a == 32'hFFFF_FFF0);
    inr = (a < BYTES);
    err = !legal || (!inr && !mm) || ((a % n) != 0) || (we && sz >= 3'd4) || (mm && sz != 3'd2);
    rd  = '0;
    if (!err) begin
      if (mm) begin
        if (we) mseg = wd;
        else    rd = mseg;
      end else if (we) begin
        for (int unsigned i = 0; i < n; i++) mbytes[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
        if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // One complete transaction on the LAT instance; call just after a negedge while idle
  task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    int          k;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    check("ready_idle", 32'(req_ready), 32'd1);
    mdl_access(we, a, sz, wd, erd, eer);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_size = 3'($urandom); req_wdata = $urandom;
    k = 0;
    do begin
      @(negedge clk); k++;
      check("ready_busy", 32'(req_ready), 32'd0);
    end while (!resp_valid && k < 40);
    check("latency", 32'(k), 32'(LAT + 1));
    check("rdata", resp_rdata, erd);
    check("err", 32'(resp_err), 32'(eer));
    rd = resp_rdata; er = resp_err;
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  task automatic gen_req(output logic we, output logic [31:0] a, output logic [2:0] sz,
                         output logic [31:0] wd);
    int unsigned r;
    logic [2:0]  szt [5];
    szt[0] = 3'd0; szt[1] = 3'd1; szt[2] = 3'd2; szt[3] = 3'd4; szt[4] = 3'd5;
    we = 1'($urandom_range(0, 1));
    wd = $urandom;
    r  = $urandom_range(0, 99);
    if      (r < 50) a = $urandom_range(0, 63);
    else if (r < 85) a = $urandom_range(0, BYTES - 1);
    else if (r < 92) a = BYTES + $urandom_range(0, 4095);
    else if (r < 97) a = 32'hFFFF_FFF0;
    else             a = $urandom;
    r  = $urandom_range(0, 99);
    sz = (r < 85) ? szt[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
  endtask

  // Per-cycle randomized traffic; stream=1 holds req_valid high throughout
  task automatic run_random(input int ncyc, input logic stream);
    int          last_acc;
    logic        ev;
    exp_t        e;
    logic [31:0] erd;
    logic        eer;
    last_acc = -1;
    for (int c = 0; c < ncyc + int'(LAT) + 4; c++) begin
      @(negedge clk); cyc++;
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("rnd_ready", 32'(req_ready), 32'(q.size() == 0));
      check("rnd_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        e = q.pop_front();
        check("rnd_rdata", resp_rdata, e.rd);
        check("rnd_err", 32'(resp_err), 32'(e.err));
      end
      gen_req(req_we, req_addr, req_size, req_wdata);
      if (c < ncyc) req_valid = stream ? 1'b1 : ($urandom_range(0, 3) != 0);
      else          req_valid = 1'b0;
      if (req_valid && req_ready) begin
        mdl_access(req_we, req_addr, req_size, req_wdata, erd, eer);
        q.push_back('{cyc + int'(LAT) + 1, erd, eer});
        if (stream && last_acc >= 0) check("stream_gap", 32'(cyc - last_acc), 32'(LAT + 2));
        last_acc = cyc;
      end
    end
    check("drained", 32'(q.size()), 32'd0);
  endtask

  // One transaction on the zero-latency instance with literal expectations
  task automatic z_xact(input logic we, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    z_valid = 1'b1; z_we = we; z_addr = a; z_size = sz; z_wdata = wd;
    check("z_ready_idle", 32'(z_ready), 32'd1);
    @(posedge clk); #1;
    z_valid = 1'b0; z_addr = $urandom; z_wdata = $urandom; z_size = 3'($urandom);
    @(negedge clk);
    check("z_valid_next", 32'(z_resp_valid), 32'd1);
    check("z_ready_resp", 32'(z_ready), 32'd0);
    check("z_rdata", z_resp_rdata, exp_rd);
    check("z_err", 32'(z_resp_err), 32'(exp_err));
    @(negedge clk);
    check("z_valid_drop", 32'(z_resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < int'(BYTES); i++) mbytes[i] = 8'h00;
    mseg = '0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    z_valid = 1'b0; z_we = 1'b0; z_addr = '0; z_size = '0; z_wdata = '0;
    repeat (3) @(negedge clk);
    check("ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_seg", seg_out, 32'd0);

    // Known memory contents so the model and the array agree everywhere
    for (int w = 0; w < int'(DEPTH); w++) xact(1'b1, 32'(w * 4), 3'd2, 32'd0, rd, er);

    // Directed cases
    xact(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd, er);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 3'd2, 32'd0, rd, er);
    check("ld_w10", rd, 32'hDEAD_BEEF);
    xact(1'b1, 32'h13, 3'd0, 32'h0000_0080, rd, er);
    xact(1'b0, 32'h13, 3'd0, 32'd0, rd, er);
    check("ld_b13", rd, 32'hFFFF_FF80);
    xact(1'b0, 32'h13, 3'd4, 32'd0, rd, er);
    check("ld_bu13", rd, 32'h0000_0080);
    xact(1'b0, 32'h10, 3'd2, 32'd0, rd, er);
    check("ld_w10_after_b", rd, 32'h80AD_BEEF);
    xact(1'b0, 32'h11, 3'd1, 32'd0, rd, er);
    check("ld_h_misalign_err", 32'(er), 32'd1);
    check("ld_h_misalign_rd", rd, 32'd0);
    xact(1'b1, 32'h12, 3'd2, 32'h1111_1111, rd, er);
    check("st_w_misalign_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10, 3'd2, 32'd0, rd, er);
    check("mem_unchanged", rd, 32'h80AD_BEEF);
    xact(1'b0, 32'h800, 3'd2, 32'd0, rd, er);
    check("ld_oor_err", 32'(er), 32'd1);
    xact(1'b1, 32'h10, 3'd4, 32'hFF, rd, er);
    check("st_bu_err", 32'(er), 32'd1);
    xact(1'b0, 32'h14, 3'd5, 32'd0, rd, er);
    check("ld_hu_zero", rd, 32'd0);

    // MMIO register
    xact(1'b1, 32'hFFFF_FFF0, 3'd2, 32'h0000_1234, rd, er);
    check("mmio_st_err", 32'(er), 32'(!MMIO));
    check("mmio_seg", seg_out, MMIO ? 32'h0000_1234 : 32'd0);
    xact(1'b0, 32'hFFFF_FFF0, 3'd2, 32'd0, rd, er);
    check("mmio_ld", rd, MMIO ? 32'h0000_1234 : 32'd0);
    xact(1'b0, 32'hFFFF_FFF0, 3'd0, 32'd0, rd, er);
    check("mmio_byte_err", 32'(er), 32'd1);

    // Reset during a store's wait states aborts it
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 3'd2; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    xact(1'b0, 32'h20, 3'd2, 32'd0, rd, er);
    check("abort_old_value", rd, 32'd0);
    check("abort_seg_cleared", seg_out, 32'd0);
    mseg = '0;

    // Zero-latency instance
    z_xact(1'b1, 32'h40, 3'd2, 32'h5A5A_1234, 32'd0, 1'b0);
    z_xact(1'b0, 32'h40, 3'd2, 32'd0, 32'h5A5A_1234, 1'b0);
    z_xact(1'b0, 32'h41, 3'd0, 32'd0, 32'h0000_0012, 1'b0);
    z_xact(1'b0, 32'h42, 3'd1, 32'd0, 32'h0000_5A5A, 1'b0);
    z_xact(1'b0, 32'h43, 3'd1, 32'd0, 32'd0, 1'b1);

    // Randomized traffic: back-to-back then sparse
    run_random(600, 1'b1);
    run_random(2000, 1'b0);
    check("final_seg", seg_out, mseg);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
